sort_dispatch_ctrl: RTL

Front-end scheduler for the odd-even merge sort network in the shared-cache switch. It gathers per-input-port cells into one frame and launches the frame into the pipelined sort network. It tracks in-flight frames with a token pipe, captures sorted frames into an output FIFO, and throttles launches with a credit count so the FIFO never overflows.

---
 rtl/sort_dispatch_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/sort_dispatch_ctrl.sv
// Front-end scheduler for the odd-even merge sort network: gathers port cells into frames,
// launches them under credit control, tracks them with a token pipe and buffers sorted frames.
module sort_dispatch_ctrl #(
    parameter  int PORT_NUB     = 8,
    parameter  int DATA_WIDTH   = 32,
    parameter  int SORT_LATENCY = 6,
    parameter  int MAX_WAIT     = 4,
    parameter  int FIFO_DEPTH   = 4,
    localparam int L            = $clog2(PORT_NUB),
    localparam int W            = 1 + 2*L + DATA_WIDTH,
    localparam int WT           = PORT_NUB*W
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [PORT_NUB-1:0]            in_valid,
    input  logic [PORT_NUB*L-1:0]          in_dest,
    input  logic [PORT_NUB*DATA_WIDTH-1:0] in_data,
    output logic [PORT_NUB-1:0]            in_ready,
    output logic [WT-1:0]                  sort_in,
    input  logic [WT-1:0]                  sort_out,
    output logic                           out_valid,
    output logic [WT-1:0]                  out_frame,
    output logic [L:0]                     out_cnt,
    input  logic                           out_ready,
    output logic                           busy
);

    localparam int CW   = L + 1;
    localparam int FL   = $clog2(FIFO_DEPTH);
    localparam int FCW  = FL + 1;
    localparam int WW   = $clog2(MAX_WAIT + 2);
    localparam int OW   = $clog2(SORT_LATENCY + FIFO_DEPTH + 2) + 1;

    logic [WT-1:0]       r_sort_in;
    logic [SORT_LATENCY:0] r_tok;
    logic [CW-1:0]       r_tok_cnt [SORT_LATENCY+1];
    logic [WT-1:0]       r_mem     [FIFO_DEPTH];
    logic [CW-1:0]       r_mem_cnt [FIFO_DEPTH];
    logic [FL-1:0]       r_wr_ptr;
    logic [FL-1:0]       r_rd_ptr;
    logic [FCW-1:0]      r_fifo_cnt;
    logic [WW-1:0]       r_wait;

    logic                w_any;
    logic                w_all;
    logic                w_credit;
    logic                w_launch;
    logic                w_push;
    logic                w_pop;
    logic [OW-1:0]       w_occ;
    logic [CW-1:0]       w_nvalid;
    logic [WT-1:0]       w_frame;

    // Occupancy counts every frame already committed to a FIFO slot: in flight or stored.
    always_comb begin
        w_occ = OW'(r_fifo_cnt);
        for (int k = 0; k <= SORT_LATENCY; k++) begin
            w_occ = w_occ + OW'(r_tok[k]);
        end
    end

    always_comb begin
        w_frame  = '0;
        w_nvalid = '0;
        for (int i = 0; i < PORT_NUB; i++) begin
            if (in_valid[i]) begin
                w_frame[i*W +: W] = {1'b1, in_dest[i*L +: L], L'(i),
                                     in_data[i*DATA_WIDTH +: DATA_WIDTH]};
                w_nvalid          = w_nvalid + CW'(1);
            end
        end
    end

    assign w_any    = |in_valid;
    assign w_all    = &in_valid;
    assign w_credit = (w_occ < OW'(FIFO_DEPTH));
    assign w_launch = rst_n & w_credit & w_any & (w_all | (r_wait == WW'(MAX_WAIT)));
    assign w_push   = r_tok[SORT_LATENCY];
    assign w_pop    = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wait     <= '0;
            r_tok      <= '0;
            r_sort_in  <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (!w_any || w_launch) begin
                r_wait <= '0;
            end else if (r_wait != WW'(MAX_WAIT)) begin
                r_wait <= r_wait + WW'(1);
            end
            r_tok     <= {r_tok[SORT_LATENCY-1:0], w_launch};
            r_sort_in <= w_launch ? w_frame : '0;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + FL'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + FL'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + FCW'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - FCW'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    // Payload storage carries no reset; the token and FIFO count decide what is meaningful.
    always_ff @(posedge clk) begin
        r_tok_cnt[0] <= w_nvalid;
        for (int k = 1; k <= SORT_LATENCY; k++) begin
            r_tok_cnt[k] <= r_tok_cnt[k-1];
        end
        if (w_push) begin
            r_mem[r_wr_ptr]     <= sort_out;
            r_mem_cnt[r_wr_ptr] <= r_tok_cnt[SORT_LATENCY];
        end
    end

    assign in_ready  = {PORT_NUB{w_launch}};
    assign sort_in   = r_sort_in;
    assign out_valid = (r_fifo_cnt != '0);
    assign out_frame = out_valid ? r_mem[r_rd_ptr] : '0;
    assign out_cnt   = out_valid ? r_mem_cnt[r_rd_ptr] : '0;
    assign busy      = (|r_tok) | out_valid;

endmodule
